// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Shared types and constants for the PWM channel bank.
//   - pwm_ch_cfg_t : per-channel compare configuration {on, off, full_on, full_off}
//   - PWM_CH_RESET : reset value of every shadow/active entry (forced off)
//   - MIN_PRESCALE : smallest prescaler reload; smaller requests are raised to it
//   - pwm_level()  : priority-ordered compare producing the raw channel level
// -----------------------------------------------------------------------------
package pwm_pkg;

    // Compare fields are held at a fixed maximum width so one struct serves
    // every CNT_WIDTH instance. Users zero-extend their CNT_WIDTH values into
    // it; the unused upper bits are constant zero and drop out in synthesis.
    localparam int PWM_CNT_MAX_W = 32;

    localparam int MIN_PRESCALE = 3;

    typedef struct packed {
        logic [PWM_CNT_MAX_W-1:0] on;
        logic [PWM_CNT_MAX_W-1:0] off;
        logic                     full_on;
        logic                     full_off;
    } pwm_ch_cfg_t;

    localparam pwm_ch_cfg_t PWM_CH_RESET = '{
        on:       '0,
        off:      '0,
        full_on:  1'b0,
        full_off: 1'b1
    };

    // full_off beats full_on; equal compares mean "never on"; on > off is a
    // window that wraps through the end of the period.
    function automatic logic pwm_level(input pwm_ch_cfg_t cfg,
                                       input logic [PWM_CNT_MAX_W-1:0] cnt);
        logic lvl;
        lvl = 1'b0;
        if (cfg.full_off) begin
            lvl = 1'b0;
        end else if (cfg.full_on) begin
            lvl = 1'b1;
        end else if (cfg.on == cfg.off) begin
            lvl = 1'b0;
        end else if (cfg.on < cfg.off) begin
            lvl = (cnt >= cfg.on) && (cnt < cfg.off);
        end else begin
            lvl = (cnt >= cfg.on) || (cnt < cfg.off);
        end
        return lvl;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
//   Prescaled period counter shared by all PWM channels.
//   Ports:
//     i_clk, i_rst_n   : clock, asynchronous active-low reset
//     i_sleep          : hold prescaler/counter at 0, suppress ticks and wraps
//     i_prescale       : reload value, one tick every max(i_prescale,3)+1 clocks
//     o_counter        : current period count
//     o_wrap           : combinational, high in the cycle whose edge wraps the
//                        counter from all-ones to 0 (commit strobe)
//     o_period_start   : registered pulse while the counter reads 0 after a wrap
// -----------------------------------------------------------------------------
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH      = 12,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_sleep,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic [CNT_WIDTH-1:0]      o_counter,
    output logic                      o_wrap,
    output logic                      o_period_start
);

    logic [PRESCALE_WIDTH-1:0] r_presc;
    logic [PRESCALE_WIDTH-1:0] w_reload;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic                      r_armed;
    logic                      r_period_start;
    logic                      w_tick;

    assign w_reload = (i_prescale < PRESCALE_WIDTH'(MIN_PRESCALE))
                    ? PRESCALE_WIDTH'(MIN_PRESCALE) : i_prescale;

    // r_armed is low for the first clock after reset or sleep: the prescaler
    // sits at 0 there but must reload instead of ticking, so the first count
    // gets a full prescale interval.
    assign w_tick = r_armed && (r_presc == '0);
    assign o_wrap = w_tick && (r_cnt == '1) && !i_sleep;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc        <= '0;
            r_cnt          <= '0;
            r_armed        <= 1'b0;
            r_period_start <= 1'b0;
        end else if (i_sleep) begin
            r_presc        <= '0;
            r_cnt          <= '0;
            r_armed        <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_armed        <= 1'b1;
            r_presc        <= (r_presc == '0) ? w_reload
                                              : r_presc - PRESCALE_WIDTH'(1);
            if (w_tick) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
            r_period_start <= o_wrap;
        end
    end

    assign o_counter      = r_cnt;
    assign o_period_start = r_period_start;

endmodule

// File: rtl/pwm_channel_bank.sv
// -----------------------------------------------------------------------------
// pwm_channel_bank
//   Double-buffered multi-channel PWM engine on a shared prescaled time base.
//   Ports:
//     clk_i, rst_ni       : clock, asynchronous active-low reset
//     prescale_i          : tick every max(prescale_i,3)+1 clocks
//     sleep_i             : halt time base, drive outputs to the off level
//     invert_i            : invert all outputs
//     upd_on_wrap_i       : 1 = commit shadows at period wrap, 0 = immediate
//     cfg_we_i, cfg_ch_i  : write strobe and channel index (out of range ignored)
//     cfg_on_i, cfg_off_i : ON / OFF compare values
//     cfg_full_on_i/off_i : force high / force low
//     pwm_o               : registered PWM outputs
//     counter_o           : current period count
//     period_start_o      : one-cycle pulse when the counter wraps to 0
//     pending_o           : shadow holds data not yet committed
// -----------------------------------------------------------------------------
module pwm_channel_bank
    import pwm_pkg::*;
#(
    parameter int CHANNELS       = 16,
    parameter int CNT_WIDTH      = 12,
    parameter int PRESCALE_WIDTH = 8,
    parameter int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic                      sleep_i,
    input  logic                      invert_i,
    input  logic                      upd_on_wrap_i,
    input  logic                      cfg_we_i,
    input  logic [CH_W-1:0]           cfg_ch_i,
    input  logic [CNT_WIDTH-1:0]      cfg_on_i,
    input  logic [CNT_WIDTH-1:0]      cfg_off_i,
    input  logic                      cfg_full_on_i,
    input  logic                      cfg_full_off_i,
    output logic [CHANNELS-1:0]       pwm_o,
    output logic [CNT_WIDTH-1:0]      counter_o,
    output logic                      period_start_o,
    output logic [CHANNELS-1:0]       pending_o
);

    logic [CNT_WIDTH-1:0]     w_counter;
    logic [PWM_CNT_MAX_W-1:0] w_cnt_ext;
    logic                     w_wrap;
    pwm_ch_cfg_t              w_wr_cfg;

    pwm_timebase #(
        .CNT_WIDTH      (CNT_WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_timebase (
        .i_clk          (clk_i),
        .i_rst_n        (rst_ni),
        .i_sleep        (sleep_i),
        .i_prescale     (prescale_i),
        .o_counter      (w_counter),
        .o_wrap         (w_wrap),
        .o_period_start (period_start_o)
    );

    assign counter_o = w_counter;
    assign w_cnt_ext = PWM_CNT_MAX_W'(w_counter);

    always_comb begin
        w_wr_cfg          = PWM_CH_RESET;
        w_wr_cfg.on       = PWM_CNT_MAX_W'(cfg_on_i);
        w_wr_cfg.off      = PWM_CNT_MAX_W'(cfg_off_i);
        w_wr_cfg.full_on  = cfg_full_on_i;
        w_wr_cfg.full_off = cfg_full_off_i;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_ch_cfg_t r_shadow;
        pwm_ch_cfg_t r_active;
        logic        r_pending;
        logic        r_pwm;
        logic        w_sel;

        // Indices >= CHANNELS match no channel and are dropped here.
        assign w_sel = cfg_we_i && (cfg_ch_i == CH_W'(g));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_shadow  <= PWM_CH_RESET;
                r_active  <= PWM_CH_RESET;
                r_pending <= 1'b0;
            end else begin
                if (w_sel) begin
                    r_shadow <= w_wr_cfg;
                end
                if (upd_on_wrap_i) begin
                    // Commit reads the pre-write shadow; a write landing on
                    // the wrap cycle re-arms pending for the next period.
                    if (w_wrap && r_pending) begin
                        r_active <= r_shadow;
                    end
                    if (w_sel) begin
                        r_pending <= 1'b1;
                    end else if (w_wrap) begin
                        r_pending <= 1'b0;
                    end
                end else begin
                    // Leftover pending data from wrap mode flushes on the
                    // next cycle, except while asleep when commits stall.
                    if (w_sel) begin
                        r_active <= w_wr_cfg;
                    end else if (r_pending && !sleep_i) begin
                        r_active <= r_shadow;
                    end
                    if (w_sel || !sleep_i) begin
                        r_pending <= 1'b0;
                    end
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_pwm <= 1'b0;
            end else if (sleep_i) begin
                r_pwm <= invert_i;
            end else begin
                r_pwm <= pwm_level(r_active, w_cnt_ext) ^ invert_i;
            end
        end

        assign pwm_o[g]     = r_pwm;
        assign pending_o[g] = r_pending;
    end

endmodule

// File: tb/tb_pwm_channel_bank.sv
module tb_pwm_channel_bank;

    localparam int CHANNELS       = 4;
    localparam int CNT_WIDTH      = 4;
    localparam int PRESCALE_WIDTH = 8;
    localparam int CH_W           = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      sleep;
    logic                      invert;
    logic                      upd_on_wrap;
    logic                      cfg_we;
    logic [CH_W-1:0]           cfg_ch;
    logic [CNT_WIDTH-1:0]      cfg_on;
    logic [CNT_WIDTH-1:0]      cfg_off;
    logic                      cfg_fon;
    logic                      cfg_foff;
    logic [CHANNELS-1:0]       pwm;
    logic [CNT_WIDTH-1:0]      counter;
    logic                      pstart;
    logic [CHANNELS-1:0]       pending;

    int n_vec = 0;
    int n_err = 0;

    // Hand-computed per-count waveforms: bit k = expected level at count k.
    logic [15:0] pat_2_5   = 16'h001C;  // on=2  off=5  : 2..4
    logic [15:0] pat_12_3  = 16'hF007;  // on=12 off=3  : 12..15, 0..2
    logic [15:0] pat_0_8   = 16'h00FF;  // on=0  off=8  : 0..7
    logic [15:0] pat_4_6   = 16'h0030;  // on=4  off=6  : 4..5
    logic [15:0] pat_8_9   = 16'h0100;  // on=8  off=9  : 8

    pwm_channel_bank #(
        .CHANNELS       (CHANNELS),
        .CNT_WIDTH      (CNT_WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .CH_W           (CH_W)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .prescale_i     (prescale),
        .sleep_i        (sleep),
        .invert_i       (invert),
        .upd_on_wrap_i  (upd_on_wrap),
        .cfg_we_i       (cfg_we),
        .cfg_ch_i       (cfg_ch),
        .cfg_on_i       (cfg_on),
        .cfg_off_i      (cfg_off),
        .cfg_full_on_i  (cfg_fon),
        .cfg_full_off_i (cfg_foff),
        .pwm_o          (pwm),
        .counter_o      (counter),
        .period_start_o (pstart),
        .pending_o      (pending)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [3:0] on, input logic [3:0] off,
                      input logic fon, input logic foff);
        cfg_ch = ch; cfg_on = on; cfg_off = off; cfg_fon = fon; cfg_foff = foff;
        cfg_we = 1'b1;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    // Wait for the first sample at which the counter changes to v.
    task automatic wait_cnt(input logic [3:0] v);
        logic [3:0] last;
        bit hit;
        last = counter;
        hit  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (counter == v && last != v) begin
                hit = 1'b1;
                break;
            end
            last = counter;
        end
        if (!hit) begin
            n_vec++; n_err++;
            $display("FAIL wait_cnt: counter=%0d never moved to %0d", counter, v);
        end
    endtask

    task automatic test_reset();
        int ps_cnt, first_k, second_k;
        logic any_hi;
        rst_n = 1'b0; prescale = '0; sleep = 0; invert = 0; upd_on_wrap = 0;
        cfg_we = 0; cfg_ch = '0; cfg_on = '0; cfg_off = '0; cfg_fon = 0; cfg_foff = 0;
        cyc(2);
        n_vec++; if (pwm !== 4'b0000) begin n_err++; $display("FAIL rst_pwm: got %b want 0000", pwm); end
        n_vec++; if (counter !== 4'd0) begin n_err++; $display("FAIL rst_counter: got %0d want 0", counter); end
        n_vec++; if (pstart !== 1'b0) begin n_err++; $display("FAIL rst_pstart: got %b want 0", pstart); end
        n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL rst_pending: got %b want 0000", pending); end
        rst_n = 1'b1;
        cyc(4);
        n_vec++; if (counter !== 4'd0) begin n_err++; $display("FAIL first_tick_early: got %0d want 0", counter); end
        cyc(1);
        n_vec++; if (counter !== 4'd1) begin n_err++; $display("FAIL first_tick: got %0d want 1", counter); end
        cyc(3);
        n_vec++; if (counter !== 4'd1) begin n_err++; $display("FAIL tick_spacing_early: got %0d want 1", counter); end
        cyc(1);
        n_vec++; if (counter !== 4'd2) begin n_err++; $display("FAIL tick_spacing: got %0d want 2", counter); end
        ps_cnt = 0; first_k = -1; second_k = -1; any_hi = 1'b0;
        for (int k = 1; k <= 128; k++) begin
            cyc(1);
            any_hi |= |pwm;
            if (pstart) begin
                ps_cnt++;
                if (first_k < 0) first_k = k; else if (second_k < 0) second_k = k;
            end
        end
        n_vec++; if (ps_cnt != 2) begin n_err++; $display("FAIL pstart_count: got %0d want 2", ps_cnt); end
        n_vec++; if (first_k != 56) begin n_err++; $display("FAIL pstart_first: got cycle %0d want 56", first_k); end
        n_vec++; if (second_k - first_k != 64) begin n_err++; $display("FAIL pstart_period: got %0d want 64", second_k - first_k); end
        n_vec++; if (any_hi !== 1'b0) begin n_err++; $display("FAIL rst_pwm_idle: got high want 0"); end
    endtask

    task automatic test_compare();
        logic [3:0] prev, exp;
        wr(2'd0, 4'd2, 4'd5, 1'b0, 1'b0);
        wr(2'd1, 4'd12, 4'd3, 1'b0, 1'b0);
        prev = counter;
        for (int k = 0; k < 64; k++) begin
            cyc(1);
            exp = {2'b00, pat_12_3[prev], pat_2_5[prev]};
            n_vec++;
            if (pwm !== exp) begin n_err++; $display("FAIL cmp_win cnt=%0d: got %b want %b", prev, pwm, exp); end
            prev = counter;
        end
        invert = 1'b1;
        prev = counter;
        for (int k = 0; k < 64; k++) begin
            cyc(1);
            exp = ~{2'b00, pat_12_3[prev], pat_2_5[prev]};
            n_vec++;
            if (pwm !== exp) begin n_err++; $display("FAIL cmp_inv cnt=%0d: got %b want %b", prev, pwm, exp); end
            prev = counter;
        end
        invert = 1'b0;
        cyc(1);
    endtask

    task automatic test_priority();
        logic seen_hi, all_hi;
        wr(2'd2, 4'd0, 4'd0, 1'b1, 1'b1);
        seen_hi = 1'b0;
        for (int k = 0; k < 20; k++) begin cyc(1); seen_hi |= pwm[2]; end
        n_vec++; if (seen_hi !== 1'b0) begin n_err++; $display("FAIL prio_full_off: got high want 0"); end
        wr(2'd2, 4'd0, 4'd0, 1'b1, 1'b0);
        n_vec++; if (pwm[2] !== 1'b0) begin n_err++; $display("FAIL imm_latency1: got %b want 0", pwm[2]); end
        cyc(1);
        n_vec++; if (pwm[2] !== 1'b1) begin n_err++; $display("FAIL imm_latency2: got %b want 1", pwm[2]); end
        all_hi = 1'b1;
        for (int k = 0; k < 20; k++) begin cyc(1); all_hi &= pwm[2]; end
        n_vec++; if (all_hi !== 1'b1) begin n_err++; $display("FAIL prio_full_on: got low want 1"); end
        wr(2'd2, 4'd7, 4'd7, 1'b0, 1'b0);
        cyc(1);
        seen_hi = 1'b0;
        for (int k = 0; k < 70; k++) begin cyc(1); seen_hi |= pwm[2]; end
        n_vec++; if (seen_hi !== 1'b0) begin n_err++; $display("FAIL prio_on_eq_off: got high want 0"); end
    endtask

    task automatic test_double_buffer();
        logic [3:0] prev;
        logic [1:0] exp;
        upd_on_wrap = 1'b1;
        wait_cnt(4'd6);
        wr(2'd0, 4'd0, 4'd8, 1'b0, 1'b0);
        n_vec++; if (pending !== 4'b0001) begin n_err++; $display("FAIL db_pending_set: got %b want 0001", pending); end
        prev = counter;
        for (int k = 0; k < 80; k++) begin
            cyc(1);
            n_vec++;
            if (pwm[0] !== pat_2_5[prev]) begin n_err++; $display("FAIL db_old_wave cnt=%0d: got %b want %b", prev, pwm[0], pat_2_5[prev]); end
            prev = counter;
            if (counter == 4'd0) break;
            n_vec++; if (pending[0] !== 1'b1) begin n_err++; $display("FAIL db_pending_hold: got %b want 1", pending[0]); end
        end
        n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL db_pending_clr: got %b want 0000", pending); end
        n_vec++; if (pstart !== 1'b1) begin n_err++; $display("FAIL db_pstart: got %b want 1", pstart); end
        cyc(1);
        n_vec++; if (pwm[0] !== 1'b1) begin n_err++; $display("FAIL db_new_first: got %b want 1", pwm[0]); end
        // Pend ch1, then write ch1 again on the wrap cycle itself.
        wait_cnt(4'd5);
        wr(2'd1, 4'd4, 4'd6, 1'b0, 1'b0);
        n_vec++; if (pending !== 4'b0010) begin n_err++; $display("FAIL db_pend_ch1: got %b want 0010", pending); end
        wait_cnt(4'd15);
        cyc(3);
        wr(2'd1, 4'd8, 4'd9, 1'b0, 1'b0);
        n_vec++; if (counter !== 4'd0) begin n_err++; $display("FAIL wrapwr_counter: got %0d want 0", counter); end
        n_vec++; if (pstart !== 1'b1) begin n_err++; $display("FAIL wrapwr_pstart: got %b want 1", pstart); end
        n_vec++; if (pending !== 4'b0010) begin n_err++; $display("FAIL wrapwr_pending: got %b want 0010", pending); end
        prev = counter;
        for (int k = 0; k < 64; k++) begin
            cyc(1);
            exp = {pat_4_6[prev], pat_0_8[prev]};
            n_vec++;
            if (pwm[1:0] !== exp) begin n_err++; $display("FAIL wrapwr_p1 cnt=%0d: got %b want %b", prev, pwm[1:0], exp); end
            prev = counter;
        end
        n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL wrapwr_commit2: got %b want 0000", pending); end
        for (int k = 0; k < 64; k++) begin
            cyc(1);
            exp = {pat_8_9[prev], pat_0_8[prev]};
            n_vec++;
            if (pwm[1:0] !== exp) begin n_err++; $display("FAIL wrapwr_p2 cnt=%0d: got %b want %b", prev, pwm[1:0], exp); end
            prev = counter;
        end
    endtask

    task automatic test_sleep();
        logic bad;
        wait_cnt(4'd8);
        wr(2'd0, 4'd3, 4'd4, 1'b0, 1'b0);
        wait_cnt(4'd9);
        sleep = 1'b1; invert = 1'b1;
        cyc(1);
        n_vec++; if (counter !== 4'd0) begin n_err++; $display("FAIL slp_counter: got %0d want 0", counter); end
        n_vec++; if (pwm !== 4'b1111) begin n_err++; $display("FAIL slp_pwm: got %b want 1111", pwm); end
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (counter !== 4'd0 || pwm !== 4'b1111 || pstart !== 1'b0) bad = 1'b1;
        end
        n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL slp_hold: got activity want counter 0 pwm 1111"); end
        n_vec++; if (pending !== 4'b0001) begin n_err++; $display("FAIL slp_retain: got %b want 0001", pending); end
        wr(2'd3, 4'd0, 4'd0, 1'b1, 1'b0);
        n_vec++; if (pending !== 4'b1001) begin n_err++; $display("FAIL slp_write: got %b want 1001", pending); end
        invert = 1'b0;
        cyc(1);
        sleep = 1'b0;
        cyc(1);
        n_vec++; if (pstart !== 1'b0) begin n_err++; $display("FAIL wake_pstart: got %b want 0", pstart); end
        n_vec++; if (pwm !== 4'b0001) begin n_err++; $display("FAIL wake_pwm: got %b want 0001", pwm); end
        cyc(3);
        n_vec++; if (counter !== 4'd0) begin n_err++; $display("FAIL wake_tick_early: got %0d want 0", counter); end
        cyc(1);
        n_vec++; if (counter !== 4'd1) begin n_err++; $display("FAIL wake_tick: got %0d want 1", counter); end
        n_vec++; if (pending !== 4'b1001) begin n_err++; $display("FAIL wake_pending: got %b want 1001", pending); end
        wait_cnt(4'd0);
        n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL wake_commit: got %b want 0000", pending); end
        cyc(1);
        n_vec++; if (pwm !== 4'b1000) begin n_err++; $display("FAIL wake_new_pwm: got %b want 1000", pwm); end
    endtask

    task automatic test_async_reset();
        wait_cnt(4'd10);
        wr(2'd1, 4'd1, 4'd2, 1'b0, 1'b0);
        n_vec++; if (pending !== 4'b0010) begin n_err++; $display("FAIL ar_pending_pre: got %b want 0010", pending); end
        wait_cnt(4'd11);
        n_vec++; if (pwm !== 4'b1000) begin n_err++; $display("FAIL ar_pwm_pre: got %b want 1000", pwm); end
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++; if (counter !== 4'd0) begin n_err++; $display("FAIL ar_counter: got %0d want 0", counter); end
        n_vec++; if (pwm !== 4'b0000) begin n_err++; $display("FAIL ar_pwm: got %b want 0000", pwm); end
        n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL ar_pending: got %b want 0000", pending); end
        n_vec++; if (pstart !== 1'b0) begin n_err++; $display("FAIL ar_pstart: got %b want 0", pstart); end
        #2;
        rst_n = 1'b1;
        cyc(1);
        n_vec++; if (pwm !== 4'b0000) begin n_err++; $display("FAIL ar_pwm_post: got %b want 0000", pwm); end
        cyc(4);
        n_vec++; if (counter !== 4'd1) begin n_err++; $display("FAIL ar_resume: got %0d want 1", counter); end
        // Pending data left over from wrap mode flushes once immediate mode is selected.
        wr(2'd0, 4'd0, 4'd15, 1'b0, 1'b0);
        n_vec++; if (pending !== 4'b0001) begin n_err++; $display("FAIL flush_pre: got %b want 0001", pending); end
        upd_on_wrap = 1'b0;
        cyc(1);
        n_vec++; if (pending !== 4'b0000) begin n_err++; $display("FAIL flush_clr: got %b want 0000", pending); end
        cyc(1);
        n_vec++; if (pwm[0] !== 1'b1) begin n_err++; $display("FAIL flush_pwm: got %b want 1", pwm[0]); end
    endtask

    initial begin
        test_reset();
        test_compare();
        test_priority();
        test_double_buffer();
        test_sleep();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
